uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 8: samp_clk ticks per bit; fixed at 8, other values unsupported.
REQ-002 SHALL have port ref_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port samp_clk, input, 1: oversample strobe, asynchronous to ref_clk and much slower; each rising edge is one sample tick.
REQ-005 SHALL have port in, input, 1: serial line, inverted polarity (idle 0, start 1, data bits inverted, stop 0).
REQ-006 SHALL have port ready, output, 1: frame-complete strobe.
REQ-007 SHALL have port bit_clk, output, 1: recovered bit clock; falls at each bit boundary, rises mid-bit.
REQ-008 SHALL have port out, output, 8: last correctly framed byte, true polarity.

Function
REQ-009 SHALL pass samp_clk and in through 2-flop synchronizers into ref_clk.
REQ-010 SHALL form the sample tick as a one-ref_clk pulse on a synchronized samp_clk 0->1 edge; all logic below advances only on ticks.
REQ-011 SHALL implement states IDLE, START, DATA, STOP with a 3-bit phase counter (0..7) and a 3-bit bit index.
REQ-012 IDLE: on a tick with in==1, SHALL go to START with phase=0; this tick defines the bit boundary.
REQ-013 Phase SHALL increment by 1 per tick in START/DATA/STOP and wrap 7->0; wrap marks the next bit boundary.
REQ-014 START: at phase 4, if in==0 (glitch) SHALL return to IDLE with no output change; else continue; on wrap SHALL enter DATA with bit index 0.
REQ-015 DATA: at phase 4 SHALL sample ~in into shift register bit[index] (LSB first); on wrap, index 7 -> STOP, else index+1.
REQ-016 STOP: at phase 4, if in==0 SHALL load out with the shift register, pulse ready, and return to IDLE immediately; if in==1 (framing error) SHALL return to IDLE, out unchanged, no ready.
REQ-017 ready SHALL be high from the valid stop sample tick until the next tick (one samp_clk period), then low.
REQ-018 bit_clk SHALL be 1 when phase>=4 in START/DATA/STOP, else 0; 0 in IDLE.
REQ-019 A new start bit SHALL be accepted on the first tick in IDLE after a frame, allowing back-to-back frames with a half-bit stop.
REQ-020 out SHALL hold its value between frames.

Reset
REQ-021 While reset==0: ready=0, bit_clk=0, out=8'h00, shift register=0, state=IDLE, counters=0, synchronizers=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no ready; reception resumes from IDLE after release.

Verification
REQ-023 Reset held 2 samp_clk periods -> ready=0, out[0]=0, bit_clk=0; release with in=0 for 2 periods -> ready=0, out unchanged.
REQ-024 Frame 8'hAC (in: 1, ~bits LSB first, changed on bit_clk falling edges, then 0) -> ready pulses once, out==8'hAC.
REQ-025 Back-to-back 8'h93 then 8'h4D, next start right after ready -> two ready pulses, out 8'h93 then 8'h4D.
REQ-026 in high for 2 ticks only -> no bit_clk activity past phase 4, no ready, out unchanged.
REQ-027 Frame 8'h5A with stop bit 1 -> no ready, out keeps prior value; following good frame 8'h3C -> out==8'h3C.
REQ-028 Reset asserted during data bit 3 -> ready stays 0, out==8'h00; next full frame 8'hAC received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampling UART receiver for an inverted-polarity serial line.
// Line sense: idle 0, start 1, data bits inverted, stop 0.
// samp_clk is a slow strobe asynchronous to ref_clk. Its rising edges are
// turned into one-cycle ticks, and the whole frame engine advances on those
// ticks. out holds the last correctly framed byte in true polarity.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a tick that sees the line high (start bit)
// START  | inside the start bit; mid-bit sample rejects glitches
// DATA   | shifting in 8 data bits, LSB first, sampled at mid-bit
// STOP   | inside the stop bit; mid-bit sample decides whether to deliver

module uart_rx #(
   parameter int OVERSAMPLE = 8
) (
   input  logic       ref_clk,
   input  logic       reset,
   input  logic       samp_clk,
   input  logic       in,
   output logic       ready,
   output logic       bit_clk,
   output logic [7:0] out
);

   localparam int PH_W = $clog2(OVERSAMPLE);

   localparam logic [PH_W-1:0] PH_ZERO = '0;
   localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic            samp_s1_q, samp_s2_q, samp_s3_q;
   logic            in_s1_q, in_s2_q;
   logic            tick;
   logic            line;

   logic [1:0]      state_q, state_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic [PH_W-1:0] phase_nx;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      out_q, out_d;
   logic            ready_q, ready_d;

   // Bring the strobe and the serial line into ref_clk; the third strobe
   // flop only serves rising-edge detection.
   always_ff @(posedge ref_clk or negedge reset) begin
      if (!reset) begin
         samp_s1_q <= 1'b0;
         samp_s2_q <= 1'b0;
         samp_s3_q <= 1'b0;
         in_s1_q   <= 1'b0;
         in_s2_q   <= 1'b0;
      end else begin
         samp_s1_q <= samp_clk;
         samp_s2_q <= samp_s1_q;
         samp_s3_q <= samp_s2_q;
         in_s1_q   <= in;
         in_s2_q   <= in_s1_q;
      end
   end

   assign tick     = samp_s2_q & ~samp_s3_q;
   assign line     = in_s2_q;
   assign phase_nx = phase_q + PH_ONE;

   // Frame engine: everything below only moves on a sample tick.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      out_d   = out_q;
      ready_d = ready_q;

      if (tick) begin
         // ready lasts exactly one tick period.
         ready_d = 1'b0;

         case (state_q)
            S_IDLE: begin
               phase_d = PH_ZERO;
               idx_d   = 3'd0;
               if (line) begin
                  state_d = S_START;
               end
            end

            S_START: begin
               phase_d = phase_nx;
               if (phase_nx == PH_MID && !line) begin
                  // Line dropped before mid-bit: treat as noise.
                  state_d = S_IDLE;
                  phase_d = PH_ZERO;
               end else if (phase_q == PH_LAST) begin
                  state_d = S_DATA;
                  idx_d   = 3'd0;
               end
            end

            S_DATA: begin
               phase_d = phase_nx;
               if (phase_nx == PH_MID) begin
                  shift_d[idx_q] = ~line;
               end
               if (phase_q == PH_LAST) begin
                  if (idx_q == 3'd7) begin
                     state_d = S_STOP;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
            end

            S_STOP: begin
               phase_d = phase_nx;
               if (phase_nx == PH_MID) begin
                  // Decide at mid-stop and leave at once, so a following
                  // start bit can begin half a bit early.
                  state_d = S_IDLE;
                  phase_d = PH_ZERO;
                  idx_d   = 3'd0;
                  if (!line) begin
                     out_d   = shift_q;
                     ready_d = 1'b1;
                  end
               end
            end

            default: begin
               state_d = S_IDLE;
               phase_d = PH_ZERO;
               idx_d   = 3'd0;
            end
         endcase
      end
   end

   // Frame engine registers.
   always_ff @(posedge ref_clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         phase_q <= PH_ZERO;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         out_q   <= 8'h00;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         out_q   <= out_d;
         ready_q <= ready_d;
      end
   end

   assign bit_clk = (state_q != S_IDLE) && (phase_q >= PH_MID);
   assign ready   = ready_q;
   assign out     = out_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx. The line is driven one sample
// slot at a time: the value set on a samp_clk falling edge is what the
// receiver sees on the following tick. The reference model only tracks
// which byte should be on out and how many ready pulses must have occurred.

module tb_uart_rx;

   logic       ref_clk  = 1'b0;
   logic       samp_clk = 1'b0;
   logic       rst_n    = 1'b0;
   logic       ser_in   = 1'b0;
   logic       ready;
   logic       bit_clk;
   logic [7:0] out_w;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   logic [7:0] exp_out    = 8'h00;
   int         exp_pulses = 0;

   // Observed activity.
   int   rdy_pulses = 0;
   int   rdy_w      = 0;
   logic rdy_prev   = 1'b0;
   int   bclk_rises = 0;
   logic bclk_prev  = 1'b0;

   uart_rx #(.OVERSAMPLE(8)) dut (
      .ref_clk  (ref_clk),
      .reset    (rst_n),
      .samp_clk (samp_clk),
      .in       (ser_in),
      .ready    (ready),
      .bit_clk  (bit_clk),
      .out      (out_w)
   );

   // 100 MHz reference, sample strobe 16 reference periods, offset in phase.
   initial forever #5 ref_clk = ~ref_clk;
   initial begin
      #3;
      forever #80 samp_clk = ~samp_clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse counting and width measurement, sampled away from ref_clk rise.
   always @(negedge ref_clk) begin
      if (ready) rdy_w++;
      if (ready && !rdy_prev) rdy_pulses++;
      if (!ready && rdy_prev) begin
         chk("ready_width", rdy_w, 16);
         rdy_w = 0;
      end
      rdy_prev = ready;
      if (bit_clk && !bclk_prev) bclk_rises++;
      bclk_prev = bit_clk;
   end

   task automatic slots(input logic v, input int n);
      repeat (n) begin
         @(negedge samp_clk);
         ser_in = v;
      end
   endtask

   // Let the tick belonging to the last driven slot be processed.
   task automatic settle();
      @(posedge samp_clk);
      #60;
   endtask

   // One frame: 8-slot start, 8 inverted data bits LSB first, stop slots.
   // A bad stop is held exactly 5 slots so the next IDLE tick sees the line low.
   task automatic frame_chk(input logic [7:0] b, input logic stop_ok, input int stop_slots);
      int b0;
      b0 = bclk_rises;
      slots(1'b1, 8);
      for (int i = 0; i < 8; i++) slots(~b[i], 8);
      slots(stop_ok ? 1'b0 : 1'b1, stop_ok ? stop_slots : 5);
      if (stop_ok) begin
         exp_out = b;
         exp_pulses++;
      end
      settle();
      chk("frame_out", out_w, exp_out);
      chk("frame_pulses", rdy_pulses, exp_pulses);
      chk("frame_bitclk", bclk_rises - b0, 9);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int b0;
      logic [7:0] rb;
      logic       rok;

      // Reset held for two sample periods.
      repeat (2) @(negedge samp_clk);
      chk("rst_ready", ready, 1'b0);
      chk("rst_out0", out_w[0], 1'b0);
      chk("rst_bitclk", bit_clk, 1'b0);
      rst_n = 1'b1;
      slots(1'b0, 2);
      settle();
      chk("idle_ready", ready, 1'b0);
      chk("idle_out", out_w, 8'h00);

      // Single clean frame.
      frame_chk(8'hAC, 1'b1, 8);
      slots(1'b0, 3);

      // Back-to-back frames with a half-bit stop.
      frame_chk(8'h93, 1'b1, 5);
      frame_chk(8'h4D, 1'b1, 5);
      slots(1'b0, 3);

      // Start glitch two ticks wide.
      b0 = bclk_rises;
      slots(1'b1, 2);
      slots(1'b0, 10);
      settle();
      chk("glitch_bitclk", bclk_rises - b0, 0);
      chk("glitch_pulses", rdy_pulses, exp_pulses);
      chk("glitch_out", out_w, exp_out);

      // Framing error followed by a good frame.
      frame_chk(8'h5A, 1'b0, 5);
      slots(1'b0, 3);
      frame_chk(8'h3C, 1'b1, 8);
      slots(1'b0, 3);

      // Reset in the middle of data bit 3.
      slots(1'b1, 8);
      slots(1'b1, 8);
      slots(1'b0, 8);
      slots(1'b1, 8);
      slots(1'b0, 4);
      @(negedge samp_clk);
      rst_n  = 1'b0;
      ser_in = 1'b0;
      exp_out = 8'h00;
      slots(1'b0, 2);
      chk("midrst_ready", ready, 1'b0);
      chk("midrst_out", out_w, exp_out);
      rst_n = 1'b1;
      slots(1'b0, 3);
      settle();
      chk("midrst_pulses", rdy_pulses, exp_pulses);
      chk("midrst_out_after", out_w, exp_out);
      frame_chk(8'hAC, 1'b1, 8);

      // Random frames, random stop quality and gaps.
      for (int k = 0; k < 20; k++) begin
         rb  = 8'($urandom);
         rok = ($urandom_range(0, 3) != 0);
         frame_chk(rb, rok, int'($urandom_range(5, 8)));
         slots(1'b0, int'($urandom_range(0, 3)));
      end
      slots(1'b0, 3);
      settle();
      chk("final_pulses", rdy_pulses, exp_pulses);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
